data_write_buffer: RTL and testbench

- Sits directly downstream of the MIPS core's data-memory port (memwrite, aluout, writedata, readdata), between the core and a slow, handshaked data memory.
- Stores are posted into a small FIFO and drained to memory in the background.
- Loads are forwarded from the FIFO on a word-address hit. Otherwise they are issued to memory with priority over draining.
- A stall output tells the core to hold pc and architectural state until the access can complete.

---
 rtl/data_write_buffer_pkg.sv | 15 +
 rtl/data_write_buffer_store_fifo.sv | 96 +++++++++
 rtl/data_write_buffer.sv | 147 ++++++++++++++
 tb/tb_data_write_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_write_buffer_pkg.sv
// Shared definitions for the posted-store data write buffer.
package data_write_buffer_pkg;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int OFFSET_BITS = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_READ  = 2'd2
   } state_e;

endpackage

// File: rtl/data_write_buffer_store_fifo.sv
// Circular store queue with a parallel youngest-match lookup for load forwarding.
module store_fifo
   import data_write_buffer_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   localparam int WAW  = AW - OFFSET_BITS,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic [WAW-1:0] push_waddr,
   input  logic [DW-1:0]  push_data,
   input  logic           pop,
   input  logic           lookup_en,
   input  logic [WAW-1:0] lookup_waddr,
   output logic [WAW-1:0] head_waddr,
   output logic [DW-1:0]  head_data,
   output logic [PW:0]    count,
   output logic           full,
   output logic           empty,
   output logic           hit,
   output logic [DW-1:0]  hit_data
);

   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [PW:0]    count_q, count_d;
   logic [WAW-1:0] waddr_q [DEPTH];
   logic [WAW-1:0] waddr_d [DEPTH];
   logic [DW-1:0]  data_q  [DEPTH];
   logic [DW-1:0]  data_d  [DEPTH];
   logic [PW-1:0]  idx;
   logic [PW:0]    age;

   always_comb begin
      waddr_d = waddr_q;
      data_d  = data_q;
      head_d  = pop  ? head_q + 1'b1 : head_q;
      tail_d  = push ? tail_q + 1'b1 : tail_q;
      if (push) begin
         waddr_d[tail_q] = push_waddr;
         data_d[tail_q]  = push_data;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= waddr_d[i];
            data_q[i]  <= data_d[i];
         end
      end
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      age      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         age = (PW+1)'(i);
         if (lookup_en && (age < count_q) && (waddr_q[idx] == lookup_waddr)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

   assign head_waddr = waddr_q[head_q];
   assign head_data  = data_q[head_q];
   assign count      = count_q;
   assign full       = (count_q == (PW+1)'(DEPTH));
   assign empty      = (count_q == '0);

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store write buffer between the core data port and a handshaked memory.
//   state    | meaning
//   ST_IDLE  | no memory request outstanding
//   ST_DRAIN | writing the head store to memory
//   ST_READ  | load miss outstanding; core stalled
module data_write_buffer
   import data_write_buffer_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memwrite,
   input  logic          memread,
   input  logic [AW-1:0] aluout,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   localparam int WAW = AW - OFFSET_BITS;
   localparam int PW  = $clog2(DEPTH);

   state_e         state_q, state_d;
   logic           mem_req_q, mem_req_d;
   logic           mem_we_q, mem_we_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_wdata_q, mem_wdata_d;

   logic [WAW-1:0] word_addr;
   logic [WAW-1:0] head_waddr;
   logic [DW-1:0]  head_data;
   logic [PW:0]    count;
   logic           full, empty, hit;
   logic [DW-1:0]  hit_data;
   logic           accept, pop, read_done;
   logic [OFFSET_BITS-1:0] unused_offset;

   assign word_addr     = aluout[AW-1:OFFSET_BITS];
   assign unused_offset = aluout[OFFSET_BITS-1:0];

   store_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (accept),
      .push_waddr   (word_addr),
      .push_data    (writedata),
      .pop          (pop),
      .lookup_en    (memread),
      .lookup_waddr (word_addr),
      .head_waddr   (head_waddr),
      .head_data    (head_data),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .hit          (hit),
      .hit_data     (hit_data)
   );

   assign pop       = (state_q == ST_DRAIN) && mem_ready;
   assign read_done = (state_q == ST_READ) && mem_ready;
   // A drain completing this cycle does not free the slot until the next edge.
   assign stall     = (memwrite && full) || (memread && !hit && !read_done);
   assign accept    = memwrite && !stall;

   always_comb begin
      readdata = '0;
      if (hit) begin
         readdata = hit_data;
      end else if (memread && read_done) begin
         readdata = mem_rdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (memread && !hit) begin
               state_d    = ST_READ;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {word_addr, {OFFSET_BITS{1'b0}}};
            end else if (!empty) begin
               state_d     = ST_DRAIN;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {head_waddr, {OFFSET_BITS{1'b0}}};
               mem_wdata_d = head_data;
            end
         end
         ST_DRAIN: begin
            if (mem_ready) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         ST_READ: begin
            mem_addr_d = {word_addr, {OFFSET_BITS{1'b0}}};
            if (mem_ready) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer: posting, forwarding, full stall, miss priority, reset.
module tb_data_write_buffer;

   logic        clk;
   logic        reset;
   logic        memwrite, memread;
   logic [31:0] aluout, writedata, readdata;
   logic        stall;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t log_q[$];
   txn_t mon_t;

   data_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .memread   (memread),
      .aluout    (aluout),
      .writedata (writedata),
      .readdata  (readdata),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory-side observer: every completed handshake in order.
   always @(posedge clk) begin
      if (reset && mem_req && mem_ready) begin
         mon_t.we   = mem_we;
         mon_t.addr = mem_addr;
         mon_t.data = mem_we ? mem_wdata : mem_rdata;
         log_q.push_back(mon_t);
      end
   end

   task automatic drain(input int n);
      mem_ready = 1'b1;
      repeat (n) @(negedge clk);
      mem_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; memwrite = 1'b0; memread = 1'b0; mem_ready = 1'b1;
      aluout = '0; writedata = '0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b want 0", mem_req); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %0b want 0", stall); end
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata: got %08h want 0", readdata); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %08h want 0", mem_addr); end
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_no_req: got %0b want 0", mem_req); end
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_posted_store;
      log_q.delete();
      mem_ready = 1'b1; memwrite = 1'b1; aluout = 32'h40; writedata = 32'hDEADBEEF;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_stall: got %0b want 0", stall); end
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL post_req_early: got %0b want 0", mem_req); end
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL post_req: got req=%0b we=%0b want 1 1", mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL post_addr: got %08h want 00000040", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL post_wdata: got %08h want deadbeef", mem_wdata); end
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL post_one_cycle: got %0b want 0", mem_req); end
      checks++; if (log_q.size() != 1) begin failures++; $display("FAIL post_log_size: got %0d want 1", log_q.size()); end
      mem_ready = 1'b0;
   endtask

   task automatic test_forwarding;
      log_q.delete();
      mem_ready = 1'b0; memwrite = 1'b1; aluout = 32'h80; writedata = 32'h11;
      @(negedge clk);
      writedata = 32'h22;
      @(negedge clk);
      memwrite = 1'b0; memread = 1'b1; aluout = 32'h83;
      #1;
      checks++; if (readdata !== 32'h22) begin failures++; $display("FAIL fwd_data: got %08h want 00000022", readdata); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd_stall: got %0b want 0", stall); end
      @(negedge clk);
      memread = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
         failures++; $display("FAIL fwd_no_read: got req=%0b we=%0b addr=%08h want 1 1 00000080", mem_req, mem_we, mem_addr);
      end
      drain(8);
      checks++; if (log_q.size() != 2) begin failures++; $display("FAIL fwd_log_size: got %0d want 2", log_q.size()); end
      else begin
         checks++; if (log_q[0].data !== 32'h11 || log_q[1].data !== 32'h22 || log_q[1].addr !== 32'h80) begin
            failures++; $display("FAIL fwd_log_order: got %08h,%08h want 00000011,00000022", log_q[0].data, log_q[1].data);
         end
      end
   endtask

   task automatic test_full_stall;
      log_q.delete();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         memwrite = 1'b1; aluout = 32'(i * 4); writedata = 32'hA0 + 32'(i);
         @(negedge clk);
      end
      aluout = 32'h10; writedata = 32'hA4;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall: got %0b want 1", stall); end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_drain_same_cycle: got %0b want 1", stall); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL full_accept: got %0b want 0", stall); end
      @(negedge clk);
      memwrite = 1'b0;
      drain(14);
      checks++; if (log_q.size() != 5) begin failures++; $display("FAIL full_log_size: got %0d want 5", log_q.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (log_q[i].we !== 1'b1 || log_q[i].addr !== 32'(i * 4) || log_q[i].data !== 32'hA0 + 32'(i)) begin
               failures++; $display("FAIL full_log_%0d: got we=%0b addr=%08h data=%08h want 1 %08h %08h",
                                    i, log_q[i].we, log_q[i].addr, log_q[i].data, 32'(i * 4), 32'hA0 + 32'(i));
            end
         end
      end
   endtask

   task automatic test_miss_priority;
      log_q.delete();
      mem_ready = 1'b0; memwrite = 1'b1; aluout = 32'h100; writedata = 32'hB0;
      @(negedge clk);
      aluout = 32'h104; writedata = 32'hB1;
      @(negedge clk);
      memwrite = 1'b0; memread = 1'b1; aluout = 32'h200;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL miss_stall: got %0b want 1", stall); end
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL miss_drain_first: got we=%0b addr=%08h want 1 00000100", mem_we, mem_addr); end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL miss_stall_wr_done: got %0b want 1", stall); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL miss_gap: got req=%0b stall=%0b want 0 1", mem_req, stall); end
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
         failures++; $display("FAIL miss_read_req: got req=%0b we=%0b addr=%08h want 1 0 00000200", mem_req, mem_we, mem_addr);
      end
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      #1;
      checks++; if (readdata !== 32'hCAFEF00D) begin failures++; $display("FAIL miss_readdata: got %08h want cafef00d", readdata); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL miss_release: got %0b want 0", stall); end
      @(negedge clk);
      memread = 1'b0; mem_rdata = '0;
      #1;
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL miss_readdata_idle: got %08h want 0", readdata); end
      drain(6);
      checks++; if (log_q.size() != 3) begin failures++; $display("FAIL miss_log_size: got %0d want 3", log_q.size()); end
      else begin
         checks++; if (log_q[0].addr !== 32'h100 || log_q[1].we !== 1'b0 || log_q[1].addr !== 32'h200 ||
                       log_q[1].data !== 32'hCAFEF00D || log_q[2].addr !== 32'h104 || log_q[2].data !== 32'hB1) begin
            failures++; $display("FAIL miss_log_order: got %08h,%08h(we=%0b),%08h want 00000100,00000200(we=0),00000104",
                                 log_q[0].addr, log_q[1].addr, log_q[1].we, log_q[2].addr);
         end
      end
   endtask

   task automatic test_reset_mid_drain;
      log_q.delete();
      mem_ready = 1'b0; memwrite = 1'b1; aluout = 32'h300; writedata = 32'hC3;
      @(negedge clk);
      memwrite = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstm_req_before: got %0b want 1", mem_req); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstm_async_req: got %0b want 0", mem_req); end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (log_q.size() != 0) begin failures++; $display("FAIL rstm_no_requests: got %0d want 0", log_q.size()); end
      mem_ready = 1'b0; memread = 1'b1; aluout = 32'h300;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rstm_discarded: got stall=%0b want 1", stall); end
      @(negedge clk);
      memread = 1'b0;
   endtask

   initial begin
      test_reset();
      test_posted_store();
      test_forwarding();
      test_full_stall();
      test_miss_priority();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
